// File: rtl/wb_sched.sv
// rtl/wb_sched.sv - register-file write-back scheduler
// Round-robin EX/MEM write port sharing, pending scoreboard, post-reset x1..x31 clear.
module wb_sched #(
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_data,
  output logic        ex_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        rf_write_en,
  output logic [4:0]  rf_rd_addr,
  output logic [31:0] rf_rd_data,
  output logic        init_done
);

  typedef enum logic {S_INIT, S_RUN} state_t;
  localparam logic PRIO_EX  = 1'b0;
  localparam logic PRIO_MEM = 1'b1;

  state_t      state, state_n;
  logic [4:0]  cnt;
  logic        prio;
  logic [31:0] pending, pending_n;
  logic        run;
  logic        ex_grant, mem_grant;

  // Readies are gated by rst_n so nothing handshakes during the reset cycle.
  assign run       = rst_n && (state == S_RUN);
  assign ex_ready  = run && (!mem_valid || prio == PRIO_EX);
  assign mem_ready = run && (!ex_valid || prio == PRIO_MEM);
  assign ex_grant  = ex_valid && ex_ready;
  assign mem_grant = mem_valid && mem_ready;

  assign issue_ready = run && !pending[issue_rd];
  assign init_done   = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT_CLEAR ? S_INIT : S_RUN;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (state == S_INIT && cnt == 5'd31) begin
      state_n = S_RUN;
    end
  end

  always_comb begin
    rf_write_en = 1'b0;
    rf_rd_addr  = 5'd0;
    rf_rd_data  = 32'd0;
    rs1_busy    = pending[rs1_addr];
    rs2_busy    = pending[rs2_addr];
    if (state == S_INIT) begin
      rs1_busy = (rs1_addr != 5'd0);
      rs2_busy = (rs2_addr != 5'd0);
      if (rst_n) begin
        rf_write_en = 1'b1;
        rf_rd_addr  = cnt;
      end
    end else if (ex_grant) begin
      rf_write_en = (ex_rd != 5'd0);
      rf_rd_addr  = ex_rd;
      rf_rd_data  = ex_data;
    end else if (mem_grant) begin
      rf_write_en = (mem_rd != 5'd0);
      rf_rd_addr  = mem_rd;
      rf_rd_data  = mem_data;
    end
  end

  // Clear before set: an older write-back never cancels a freshly issued claim.
  always_comb begin
    pending_n = pending;
    if (ex_grant) begin
      pending_n[ex_rd] = 1'b0;
    end else if (mem_grant) begin
      pending_n[mem_rd] = 1'b0;
    end
    if (issue_valid && issue_ready) begin
      pending_n[issue_rd] = 1'b1;
    end
    pending_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= 5'd1;
      prio    <= PRIO_EX;
      pending <= 32'd0;
    end else begin
      if (state == S_INIT) begin
        cnt <= cnt + 5'd1;
      end
      if (ex_grant) begin
        prio <= PRIO_MEM;
      end else if (mem_grant) begin
        prio <= PRIO_EX;
      end
      pending <= pending_n;
    end
  end

endmodule

// File: tb/tb_wb_sched.sv
// tb/tb_wb_sched.sv - directed self-checking bench for wb_sched
module tb_wb_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ex_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        rf_write_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        init_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_sched #(.INIT_CLEAR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_write_en(rf_write_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .init_done(init_done)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = 5'd0;
    ex_valid = 1'b0; ex_rd = 5'd0; ex_data = 32'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    rs1_addr = 5'd9; rs2_addr = 5'd0;
  endtask

  // Entered at a negedge with rst_n just released; exits at the negedge of cycle 32.
  task automatic run_sweep(input string tag);
    for (int i = 1; i <= 31; i++) begin
      #1;
      n_tests++;
      if (rf_write_en !== 1'b1 || rf_rd_addr !== 5'(i) || rf_rd_data !== 32'd0) begin
        n_fail++;
        $display("FAIL %s sweep[%0d]: got en=%b addr=%0d data=%h, want en=1 addr=%0d data=0",
                 tag, i, rf_write_en, rf_rd_addr, rf_rd_data, i);
      end
      n_tests++;
      if ({issue_ready, ex_ready, mem_ready, rs1_busy, init_done} !== 5'b00010) begin
        n_fail++;
        $display("FAIL %s sweep_ctl[%0d]: got iss/ex/mem/busy/done=%b, want 00010",
                 tag, i, {issue_ready, ex_ready, mem_ready, rs1_busy, init_done});
      end
      tick();
    end
    #1;
    n_tests++;
    if (init_done !== 1'b1 || rf_write_en !== 1'b0) begin
      n_fail++;
      $display("FAIL %s init_done: got done=%b en=%b, want done=1 en=0", tag, init_done, rf_write_en);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    #1;
    n_tests++;
    if ({init_done, rf_write_en, rf_rd_addr, rf_rd_data, issue_ready, ex_ready, mem_ready} !== 42'd0) begin
      n_fail++;
      $display("FAIL reset_state: got done=%b en=%b addr=%0d data=%h iss=%b ex=%b mem=%b, want all 0",
               init_done, rf_write_en, rf_rd_addr, rf_rd_data, issue_ready, ex_ready, mem_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep("reset");
  endtask

  task automatic test_arbitration();
    logic [4:0]  exp_addr [4];
    logic [31:0] exp_data [4];
    exp_addr = '{5'd3, 5'd4, 5'd3, 5'd4};
    exp_data = '{32'hA, 32'hB, 32'hA, 32'hB};
    ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'hA;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (rf_write_en !== 1'b1 || rf_rd_addr !== exp_addr[i] || rf_rd_data !== exp_data[i] ||
          ex_ready !== (i % 2 == 0) || mem_ready !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL arb[%0d]: got en=%b addr=%0d data=%h exr=%b memr=%b, want en=1 addr=%0d data=%h exr=%b memr=%b",
                 i, rf_write_en, rf_rd_addr, rf_rd_data, ex_ready, mem_ready,
                 exp_addr[i], exp_data[i], (i % 2 == 0), (i % 2 == 1));
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rd = 5'd5; rs1_addr = 5'd5;
    #1;
    n_tests++;
    if (issue_ready !== 1'b1 || rs1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_issue: got ready=%b busy=%b, want ready=1 busy=0", issue_ready, rs1_busy);
    end
    tick();
    #1;
    n_tests++;
    if (issue_ready !== 1'b0 || rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_stall: got ready=%b busy=%b, want ready=0 busy=1", issue_ready, rs1_busy);
    end
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h55;
    #1;
    n_tests++;
    if (mem_ready !== 1'b1 || rf_write_en !== 1'b1 || rf_rd_addr !== 5'd5 ||
        rf_rd_data !== 32'h55 || rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_wb: got memr=%b en=%b addr=%0d data=%h busy=%b, want 1 1 5 55 1",
               mem_ready, rf_write_en, rf_rd_addr, rf_rd_data, rs1_busy);
    end
    tick();
    mem_valid = 1'b0;
    #1;
    n_tests++;
    if (rs1_busy !== 1'b0 || issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_release: got busy=%b ready=%b, want busy=0 ready=1", rs1_busy, issue_ready);
    end
    idle_inputs();
  endtask

  task automatic test_x0();
    ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    n_tests++;
    if (ex_ready !== 1'b1 || rf_write_en !== 1'b0 || issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_write: got exr=%b en=%b iss=%b, want exr=1 en=0 iss=1",
               ex_ready, rf_write_en, issue_ready);
    end
    tick();
    idle_inputs();
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    n_tests++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_busy: got b1=%b b2=%b iss=%b, want 0 0 1", rs1_busy, rs2_busy, issue_ready);
    end
  endtask

  task automatic test_back_to_back();
    issue_valid = 1'b1; issue_rd = 5'd6;
    tick();
    issue_rd = 5'd7;
    ex_valid = 1'b1; ex_rd = 5'd6; ex_data = 32'h66;
    #1;
    n_tests++;
    if (issue_ready !== 1'b1 || ex_ready !== 1'b1 || rf_rd_addr !== 5'd6) begin
      n_fail++;
      $display("FAIL b2b_same_cycle: got iss=%b exr=%b addr=%0d, want 1 1 6",
               issue_ready, ex_ready, rf_rd_addr);
    end
    tick();
    idle_inputs();
    rs1_addr = 5'd7; rs2_addr = 5'd6;
    #1;
    n_tests++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_pending: got p7=%b p6=%b, want p7=1 p6=0", rs1_busy, rs2_busy);
    end
  endtask

  task automatic test_reset_mid_init();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i < 10; i++) tick();
    #1;
    n_tests++;
    if (rf_rd_addr !== 5'd10 || rf_write_en !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_init_pos: got addr=%0d en=%b, want addr=10 en=1", rf_rd_addr, rf_write_en);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (rf_write_en !== 1'b0 || ex_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_init_rst: got en=%b exr=%b, want en=0 exr=0", rf_write_en, ex_ready);
    end
    tick();
    rst_n = 1'b1;
    run_sweep("mid_init");
  endtask

  task automatic test_reset_mid_run();
    issue_valid = 1'b1; issue_rd = 5'd8;
    ex_valid = 1'b1; ex_rd = 5'd9; ex_data = 32'h99;
    tick();
    idle_inputs();
    rs1_addr = 5'd8;
    #1;
    n_tests++;
    if (rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_run_pre: got busy8=%b, want 1", rs1_busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rs1_addr = 5'd9;
    run_sweep("mid_run");
    rs1_addr = 5'd8; issue_rd = 5'd8;
    ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'hA;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'hB;
    #1;
    n_tests++;
    if (rs1_busy !== 1'b0 || issue_ready !== 1'b1 || rf_rd_addr !== 5'd3 || ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_run_post: got busy8=%b iss=%b addr=%0d exr=%b, want 0 1 3 1",
               rs1_busy, issue_ready, rf_rd_addr, ex_ready);
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_arbitration();
    test_scoreboard();
    test_x0();
    test_back_to_back();
    test_reset_mid_init();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_sched.md
# wb_sched

Write-back scheduler for the integer register file. Owns the file's single write port and shares it between the execute unit and the memory/load unit with round-robin arbitration. Keeps a per-register pending scoreboard so issue logic can detect RAW/WAW hazards. After reset it sequences a clear of x1..x31 before any traffic is admitted.

## Interface

Parameters:
- INIT_CLEAR, 1: 1 = zero-sweep x1..x31 after reset; 0 = skip the sweep and enter RUN directly.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- issue_valid  in  1  issue stage presents an instruction that writes issue_rd.
- issue_rd  in  5 (reg_addr_t)  destination of the issuing instruction.
- issue_ready  out  1  issue accepted this cycle when high together with issue_valid.
- rs1_addr, rs2_addr  in  5 (reg_addr_t)  source registers under hazard check.
- rs1_busy, rs2_busy  out  1  source has an outstanding write.
- ex_valid  in  1  execute unit write-back request.
- ex_rd  in  5 (reg_addr_t)  execute write-back destination.
- ex_data  in  32 (word_t)  execute write-back data.
- ex_ready  out  1  execute write-back accepted.
- mem_valid, mem_rd, mem_data, mem_ready  in/in/in/out  1/5/32/1  same as the ex_* group, for the load unit.
- rf_write_en  out  1  register-file write enable.
- rf_rd_addr  out  5 (reg_addr_t)  register-file write address.
- rf_rd_data  out  32 (word_t)  register-file write data.
- init_done  out  1  high once the sweep completes; stays high until the next reset.

## Operation

- State machine: INIT → RUN. Reset enters INIT if INIT_CLEAR=1, otherwise RUN. RUN holds until reset.
- INIT:
  - A 5-bit counter starts at 1.
  - Each cycle drives rf_write_en=1, rf_rd_addr=counter, rf_rd_data=0, then increments the counter.
  - After writing address 31, moves to RUN.
  - issue_ready, ex_ready and mem_ready are 0.
  - rs*_busy is 1 for any nonzero address.
- RUN arbitration:
  - A priority flag prio resets to EX.
  - ex_ready = !mem_valid | prio==EX.
  - mem_ready = !ex_valid | prio==MEM.
  - Exactly one requester is granted per cycle; grant = valid & ready.
  - A grant to EX sets prio=MEM; a grant to MEM sets prio=EX. No grant leaves prio unchanged.
  - rf_* outputs are combinational from the granted requester, so the write lands on the same clock edge as the handshake.
  - rf_write_en = grant & (granted rd != 0). A write to x0 is accepted (ready high) but never reaches the file.
  - With no grant: rf_write_en=0, rf_rd_addr=0, rf_rd_data=0.
- Scoreboard:
  - 32 pending bits, all 0 at reset.
  - Bit 0 is hard-wired to 0.
  - issue_ready = RUN & !pending[issue_rd]. An issue to x0 is always ready in RUN and sets nothing.
  - An accepted issue sets pending[issue_rd].
  - A granted write-back clears pending[granted rd].
  - A write-back to a non-pending register is still performed, with no scoreboard change.
  - The same-register set/clear collision is impossible: issue stalls while that bit is set.
  - Different registers set and cleared in the same cycle both take effect.
- Hazard outputs:
  - rsN_busy = pending[rsN_addr], read from the registered state.
  - No same-cycle bypass: a write-back granted this cycle still reads busy until the next cycle.
  - x0 is never busy.

## Timing

- Reset values:
  - init_done=0, or 1 when INIT_CLEAR=0.
  - issue_ready=0 during the reset cycle; all ready signals are 0 while rst_n=0.
  - rf_write_en=0, rf_rd_addr=0, rf_rd_data=0.
  - pending=0, prio=EX.
- Sweep: 31 cycles. The first sweep write happens in the first cycle after rst_n rises. init_done rises, and RUN begins, in cycle 32.
- Write-back latency: 0 cycles from grant to write-enable assertion; the data is in the file after the same edge.
- Scoreboard update: visible on rs*_busy and issue_ready 1 cycle after the issue or the write-back.
- Reset mid-INIT: the counter restarts at 1 and the sweep is redone in full.
- Reset mid-RUN:
  - Pending is cleared, prio returns to EX, and the sweep re-runs (INIT_CLEAR=1).
  - In-flight requests are dropped, since ready is 0 during reset and INIT.
- Requesters must hold valid/rd/data stable until they are granted.

## Test plan

- Reset with INIT_CLEAR=1 → rf_write_en=1 with addresses 1..31 and data 0 over 31 cycles. init_done=1 at cycle 32. ex_ready, mem_ready and issue_ready stay 0 throughout.
- In RUN, ex and mem both valid for 4 cycles, ex_rd=3/data=0xA, mem_rd=4/data=0xB → grants alternate EX, MEM, EX, MEM. rf_rd_addr/data follow 3/0xA and 4/0xB accordingly.
- Issue rd=5 → rs1_busy=1 for rs1_addr=5 next cycle. A second issue to rd=5 sees issue_ready=0. mem write-back to rd 5 → busy=0 and issue_ready=1 the following cycle.
- ex_valid with ex_rd=0, data=0xFFFFFFFF → ex_ready=1, rf_write_en=0. Issue rd=0 is accepted and rs1_busy for x0 stays 0.
- Issue rd=7 and EX write-back to rd=6 (pending) in the same cycle → next cycle pending[7]=1 and pending[6]=0.
- Assert rst_n=0 for 1 cycle at sweep address 10, and again in RUN with pending[8]=1 → sweep restarts at 1, and pending[8]=0 after reset.
